text_cursor_writer: RTL

Upstream feeder for the character plane. Consumes a byte stream (keyboard/UART decoded characters) over a valid/ready handshake, keeps a text cursor, and produces one-cycle write commands (we, row, col, data) for the 7x20 character memory. Handles printable characters, newline, backspace-erase and a full-screen clear sweep, including the automatic clear after reset.

---
 rtl/text_cursor_writer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/text_cursor_writer.sv
// Byte-stream to character-plane writer: keeps a text cursor and issues one-cycle
// write commands for printable bytes, newline, backspace-erase and full clear sweeps.
module text_cursor_writer #(
  parameter int unsigned          ROW_NUMBER  = 7,
  parameter int unsigned          COL_NUMBER  = 20,
  parameter int unsigned          ROW_BIT_LEN = 4,
  parameter int unsigned          COL_BIT_LEN = 6,
  parameter int unsigned          DATA_SIZE   = 8,
  parameter logic [DATA_SIZE-1:0] ERASE_CODE  = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_SIZE-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [ROW_BIT_LEN-1:0] wr_row,
  output logic [COL_BIT_LEN-1:0] wr_col,
  output logic [DATA_SIZE-1:0]   wr_data,
  output logic [ROW_BIT_LEN-1:0] cur_row,
  output logic [COL_BIT_LEN-1:0] cur_col,
  output logic                   busy
);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  localparam logic [ROW_BIT_LEN-1:0] LAST_ROW = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0] LAST_COL = COL_BIT_LEN'(COL_NUMBER - 1);
  localparam logic [DATA_SIZE-1:0]   CH_BS    = DATA_SIZE'(8'h08);
  localparam logic [DATA_SIZE-1:0]   CH_LF    = DATA_SIZE'(8'h0A);
  localparam logic [DATA_SIZE-1:0]   CH_FF    = DATA_SIZE'(8'h0C);
  localparam logic [DATA_SIZE-1:0]   CH_CR    = DATA_SIZE'(8'h0D);
  localparam logic [DATA_SIZE-1:0]   CH_SPACE = DATA_SIZE'(8'h20);

  state_t                 state_q, state_d;
  logic                   wr_en_q, wr_en_d;
  logic [ROW_BIT_LEN-1:0] wr_row_q, wr_row_d;
  logic [COL_BIT_LEN-1:0] wr_col_q, wr_col_d;
  logic [DATA_SIZE-1:0]   wr_data_q, wr_data_d;
  logic [ROW_BIT_LEN-1:0] cur_row_q, cur_row_d;
  logic [COL_BIT_LEN-1:0] cur_col_q, cur_col_d;
  logic [ROW_BIT_LEN-1:0] sw_row_q, sw_row_d;
  logic [COL_BIT_LEN-1:0] sw_col_q, sw_col_d;
  logic                   accept;

  assign accept = in_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    sw_row_d  = sw_row_q;
    sw_col_d  = sw_col_q;

    case (state_q)
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_row_d  = sw_row_q;
        wr_col_d  = sw_col_q;
        wr_data_d = ERASE_CODE;
        if (sw_col_q == LAST_COL) begin
          sw_col_d = '0;
          if (sw_row_q == LAST_ROW) begin
            sw_row_d  = '0;
            cur_row_d = '0;
            cur_col_d = '0;
            state_d   = ST_IDLE;
          end else begin
            sw_row_d = sw_row_q + 1'b1;
          end
        end else begin
          sw_col_d = sw_col_q + 1'b1;
        end
      end

      ST_IDLE: begin
        if (accept) begin
          if (in_data >= CH_SPACE) begin
            wr_en_d   = 1'b1;
            wr_row_d  = cur_row_q;
            wr_col_d  = cur_col_q;
            wr_data_d = in_data;
            if (cur_col_q == LAST_COL) begin
              cur_col_d = '0;
              cur_row_d = (cur_row_q == LAST_ROW) ? '0 : cur_row_q + 1'b1;
            end else begin
              cur_col_d = cur_col_q + 1'b1;
            end
          end else if (in_data == CH_LF || in_data == CH_CR) begin
            cur_col_d = '0;
            cur_row_d = (cur_row_q == LAST_ROW) ? '0 : cur_row_q + 1'b1;
          end else if (in_data == CH_BS) begin
            // Erase lands on the cell the cursor moves back onto; home is a no-op.
            if (cur_col_q != '0) begin
              cur_col_d = cur_col_q - 1'b1;
              wr_en_d   = 1'b1;
              wr_row_d  = cur_row_q;
              wr_col_d  = cur_col_q - 1'b1;
              wr_data_d = ERASE_CODE;
            end else if (cur_row_q != '0) begin
              cur_row_d = cur_row_q - 1'b1;
              cur_col_d = LAST_COL;
              wr_en_d   = 1'b1;
              wr_row_d  = cur_row_q - 1'b1;
              wr_col_d  = LAST_COL;
              wr_data_d = ERASE_CODE;
            end
          end else if (in_data == CH_FF) begin
            sw_row_d = '0;
            sw_col_d = '0;
            state_d  = ST_CLEAR;
          end
        end
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
      cur_row_q <= '0;
      cur_col_q <= '0;
      sw_row_q  <= '0;
      sw_col_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      sw_row_q  <= sw_row_d;
      sw_col_q  <= sw_col_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_CLEAR);
  assign wr_en    = wr_en_q;
  assign wr_row   = wr_row_q;
  assign wr_col   = wr_col_q;
  assign wr_data  = wr_data_q;
  assign cur_row  = cur_row_q;
  assign cur_col  = cur_col_q;

endmodule
